multicore_normalizer: RTL and testbench
=======================================

# multicore_normalizer

Single-clock, parametrised successor to the two-core normalizer path: it collects one signed partial-sum vector from each of `N_CORE` systolic cores. It accumulates the L1 norm S = Σ|psum| over all `N_CORE*COL` elements and streams out every element as an unsigned fraction |psum|/S with a separate sign bit. It sits downstream of the core array's `out` buses. A valid/ready handshake on both sides supports any core count and output backpressure.

## Interface
- `N_CORE`, 2, number of cores feeding the block (≥1)
- `COL`, 8, psum elements per core
- `BW_PSUM`, 11, width of one signed psum element
- `W_OUT`, 11, fraction bits of the normalized output

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `psum`  in  N_CORE*COL*BW_PSUM  element j of core k at bits [(k*COL+j)*BW_PSUM +: BW_PSUM], two's complement
- `s_valid`  in  N_CORE  per-core vector valid
- `s_ready`  out  N_CORE  per-core capture ready
- `psum_norm`  out  W_OUT  unsigned Q0.W_OUT magnitude |x|/S
- `norm_sign`  out  1  1 when the source element was negative
- `norm_idx`  out  clog2(N_CORE*COL)  element index k*COL+j
- `norm_valid`  out  1  output element valid
- `norm_last`  out  1  high with the final element (idx N_CORE*COL-1)
- `norm_ready`  in  1  downstream accept
- `busy`  out  1  high whenever state ≠ COLLECT

## Operation
- **States:** COLLECT, DIV, OUT.
- **COLLECT**
  - `s_ready[k] = ~captured[k]`.
  - On each edge with `s_valid[k] & s_ready[k]`: latch core k's vector, set `captured[k]`, and add Σ|elements| of that core to `sum`.
  - Several cores may be captured on the same edge, and all of their sums are added.
  - `s_valid` of a core that is already captured is ignored.
- **Widths**
  - |x| is BW_PSUM bits unsigned. |−2^(BW_PSUM−1)| = 2^(BW_PSUM−1) and does not overflow.
  - `sum` is BW_PSUM+clog2(N_CORE*COL) bits and cannot overflow.
- **COLLECT → DIV:** on the edge that captures the last outstanding core, with idx = 0.
- **DIV (S ≠ 0)**
  - Restoring divider computes Q = floor(|x|·2^W_OUT / S) over W_OUT+1 cycles: one integer bit, then W_OUT fraction bits, MSB first.
  - If the integer bit is 1 (|x| == S), the output saturates to 2^W_OUT−1.
- **DIV (S == 0):** lasts 1 cycle and yields magnitude 0, sign 0.
- **DIV → OUT:** load `psum_norm`, `norm_sign`, `norm_idx`, and `norm_last`; assert `norm_valid`.
- **OUT**
  - All output fields are held stable until `norm_valid & norm_ready`.
  - On that handshake, if not last: idx+1, go to DIV, and drop `norm_valid`.
  - On that handshake, if last: clear `captured`, clear `sum`, go to COLLECT.
- **Element order:** core 0 col 0 … col COL−1, then core 1, and so on.
- `s_ready` is all zero outside COLLECT, so no new vector is accepted while a frame is being drained.

## Timing
- **Reset values** (forced while `reset` is high, applied on the edge):
  - state COLLECT, `captured` = 0, `sum` = 0
  - `s_ready` = 0 while `reset` is high, then all ones on the first cycle after release
  - `norm_valid`, `norm_last`, `norm_sign`, `psum_norm`, `norm_idx`, `busy` = 0
- **Reset mid-operation** (any state): the frame is discarded, no further `norm_valid` is issued, and the block restarts in COLLECT.
- **Latency:**
  - Last capture edge → first `norm_valid` = W_OUT+1 cycles (S ≠ 0) or 1 cycle (S == 0).
  - Handshake → next `norm_valid` = the same DIV length.
- **Throughput:** one element per W_OUT+2 cycles (S ≠ 0) with `norm_ready` tied high.
- `norm_valid` never deasserts without a handshake or reset.
- `busy` rises on the edge entering DIV and falls on the final handshake edge.
- All outputs are registered or decoded from registered state. There is no combinational path from `norm_ready` or `s_valid` to any output.

## Test plan
All scenarios use N_CORE=2, COL=2, BW_PSUM=8, W_OUT=8.

1. **Simultaneous capture.** Core0 {4, −4} and core1 {8, 0}, both `s_valid` on the same cycle (S=16), `norm_ready` tied 1.
   - Expected outputs: (idx0, 64, +), (idx1, 64, −), (idx2, 128, +), (idx3, 0, +, last).
   - First `norm_valid` arrives 9 cycles after capture; element spacing is 10 cycles.
2. **Staggered capture.**
   - Core1 valid at cycle 2: `s_ready` goes 2'b01 from cycle 3.
   - Core0 valid at cycle 6: `busy` stays 0 until the cycle-6 edge, and results match scenario 1.
3. **Saturation.** Core0 {0, 0}, core1 {−128, 0}.
   - idx2 = 255, sign 1; all other elements 0 with sign 0.
4. **Zero frame.** All elements 0.
   - Outputs are 0 for idx 0..3, each 1 cycle after the preceding handshake, with `norm_last` on idx3.
   - `s_ready` returns to 2'b11 the next cycle.
5. **Backpressure.** Run scenario 1 with `norm_ready` low for 5 cycles during idx1.
   - idx1 outputs are held unchanged, `s_ready` stays 2'b00, and core `s_valid` pulses in this window are not captured.
6. **Reset in DIV.** Assert `reset` for 1 cycle midway through idx2's division.
   - `norm_valid` stays 0, `s_ready` is 0 during reset then 2'b11, and a new frame then produces correct results.

Source files
------------

// File: rtl/multicore_normalizer.sv
// rtl/multicore_normalizer.sv - L1-normalizes N_CORE psum vectors into a sign/fraction element stream
module multicore_normalizer #(
  parameter int N_CORE  = 2,
  parameter int COL     = 8,
  parameter int BW_PSUM = 11,
  parameter int W_OUT   = 11,
  localparam int NE     = N_CORE * COL,
  localparam int IW     = (NE > 1) ? $clog2(NE) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CORE*COL*BW_PSUM-1:0] psum,
  input  logic [N_CORE-1:0]            s_valid,
  output logic [N_CORE-1:0]            s_ready,
  output logic [W_OUT-1:0]             psum_norm,
  output logic                         norm_sign,
  output logic [IW-1:0]                norm_idx,
  output logic                         norm_valid,
  output logic                         norm_last,
  input  logic                         norm_ready,
  output logic                         busy
);

  localparam int SW = BW_PSUM + IW;
  localparam int CW = $clog2(W_OUT + 1);

  typedef enum logic [1:0] {COLLECT, DIV, OUT} state_t;

  state_t                    state;
  logic [N_CORE-1:0]         captured;
  logic [N_CORE-1:0]         cap;
  logic [SW-1:0]             sum;
  logic [SW-1:0]             add_sum;
  logic [NE*BW_PSUM-1:0]     vec_q;
  logic [IW-1:0]             idx;
  logic [CW-1:0]             cnt;
  logic [SW-1:0]             rem;
  logic [W_OUT-1:0]          q_reg;
  logic [BW_PSUM-1:0]        cur_x;
  logic [BW_PSUM-1:0]        cur_mag;
  logic [SW:0]               trial;
  logic [SW-1:0]             diff;
  logic                      q_bit;

  // Magnitude as an unsigned value; the most negative input maps onto 2^(BW_PSUM-1) exactly.
  function automatic logic [BW_PSUM-1:0] abs_val(input logic [BW_PSUM-1:0] x);
    return x[BW_PSUM-1] ? ((~x) + BW_PSUM'(1)) : x;
  endfunction

  assign s_ready = (state == COLLECT && !reset) ? ~captured : '0;
  assign cap     = s_valid & s_ready;
  assign busy    = (state != COLLECT);

  // L1 contribution of every core captured on this edge.
  always_comb begin
    add_sum = '0;
    for (int k = 0; k < N_CORE; k++) begin
      if (cap[k]) begin
        for (int j = 0; j < COL; j++) begin
          add_sum = add_sum + SW'(abs_val(psum[(k*COL+j)*BW_PSUM +: BW_PSUM]));
        end
      end
    end
  end

  // One restoring-division step: the first step uses |x| directly (integer bit), later steps the shifted remainder.
  always_comb begin
    cur_x   = vec_q[idx*BW_PSUM +: BW_PSUM];
    cur_mag = abs_val(cur_x);
    trial   = (cnt == '0) ? (SW+1)'(cur_mag) : {rem, 1'b0};
    q_bit   = (trial >= {1'b0, sum});
    diff    = trial[SW-1:0] - sum;
  end

  // Collect / divide / output sequencer with registered stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COLLECT;
      captured   <= '0;
      sum        <= '0;
      idx        <= '0;
      cnt        <= '0;
      rem        <= '0;
      q_reg      <= '0;
      psum_norm  <= '0;
      norm_sign  <= 1'b0;
      norm_idx   <= '0;
      norm_valid <= 1'b0;
      norm_last  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          for (int k = 0; k < N_CORE; k++) begin
            if (cap[k]) vec_q[k*COL*BW_PSUM +: COL*BW_PSUM] <= psum[k*COL*BW_PSUM +: COL*BW_PSUM];
          end
          captured <= captured | cap;
          sum      <= sum + add_sum;
          if (&(captured | cap)) begin
            state <= DIV;
            idx   <= '0;
            cnt   <= '0;
          end
        end
        DIV: begin
          if (sum == '0) begin
            psum_norm  <= '0;
            norm_sign  <= 1'b0;
            norm_idx   <= idx;
            norm_last  <= (idx == IW'(NE - 1));
            norm_valid <= 1'b1;
            state      <= OUT;
          end else begin
            rem   <= q_bit ? diff : trial[SW-1:0];
            q_reg <= {q_reg[W_OUT-2:0], q_bit};
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(W_OUT)) begin
              // q_reg[W_OUT-1] now holds the integer bit, set only when |x| == S.
              psum_norm  <= q_reg[W_OUT-1] ? '1 : {q_reg[W_OUT-2:0], q_bit};
              norm_sign  <= cur_x[BW_PSUM-1];
              norm_idx   <= idx;
              norm_last  <= (idx == IW'(NE - 1));
              norm_valid <= 1'b1;
              state      <= OUT;
            end
          end
        end
        OUT: begin
          if (norm_ready) begin
            norm_valid <= 1'b0;
            if (norm_last) begin
              state    <= COLLECT;
              captured <= '0;
              sum      <= '0;
            end else begin
              idx   <= idx + IW'(1);
              cnt   <= '0;
              state <= DIV;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicore_normalizer.sv
// tb/tb_multicore_normalizer.sv - directed self-checking bench for multicore_normalizer
module tb_multicore_normalizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] psum = '0;
  logic [1:0]  s_valid = '0;
  logic [1:0]  s_ready;
  logic [7:0]  psum_norm;
  logic        norm_sign;
  logic [1:0]  norm_idx;
  logic        norm_valid;
  logic        norm_last;
  logic        norm_ready = 1'b1;
  logic        busy;

  int total = 0;
  int bad   = 0;

  multicore_normalizer #(
    .N_CORE(2), .COL(2), .BW_PSUM(8), .W_OUT(8)
  ) dut (
    .clk(clk), .reset(reset), .psum(psum), .s_valid(s_valid), .s_ready(s_ready),
    .psum_norm(psum_norm), .norm_sign(norm_sign), .norm_idx(norm_idx),
    .norm_valid(norm_valid), .norm_last(norm_last), .norm_ready(norm_ready), .busy(busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] a0, input logic [7:0] a1,
                                       input logic [7:0] b0, input logic [7:0] b1);
    return {b1, b0, a1, a0};
  endfunction

  task automatic capture_both(input logic [31:0] v);
    psum    = v;
    s_valid = 2'b11;
    tick();
    s_valid = 2'b00;
    psum    = 32'hA5A5_A5A5;
  endtask

  task automatic expect_elem(input string tag, input int lat, input logic [7:0] mag,
                             input logic sgn, input logic [1:0] idx, input logic lst,
                             input int hold);
    int n;
    n = 0;
    if (hold > 0) norm_ready = 1'b0;
    while (!norm_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"},  n, lat);
    chk({tag, "_mag"},  psum_norm, mag);
    chk({tag, "_sign"}, norm_sign, sgn);
    chk({tag, "_idx"},  norm_idx, idx);
    chk({tag, "_last"}, norm_last, lst);
    for (int h = 0; h < hold; h++) begin
      s_valid = 2'b11;
      psum    = 32'h7F7F_7F7F;
      tick();
      chk({tag, "_hold"}, {norm_valid, norm_last, norm_idx, norm_sign, psum_norm},
          {1'b1, lst, idx, sgn, mag});
      chk({tag, "_hold_rdy"}, s_ready, 2'b00);
    end
    s_valid    = 2'b00;
    norm_ready = 1'b1;
    tick();
  endtask

  task automatic frame_s1(input string tag, input int hold1);
    expect_elem({tag, "e0"}, 9, 8'd64,  1'b0, 2'd0, 1'b0, 0);
    expect_elem({tag, "e1"}, 9, 8'd64,  1'b1, 2'd1, 1'b0, hold1);
    expect_elem({tag, "e2"}, 9, 8'd128, 1'b0, 2'd2, 1'b0, 0);
    expect_elem({tag, "e3"}, 9, 8'd0,   1'b0, 2'd3, 1'b1, 0);
  endtask

  // Directed scenario sequence.
  initial begin
    bit seen;

    reset = 1'b1;
    tick();
    tick();
    chk("rst_s_ready", s_ready, 2'b00);
    chk("rst_valid", norm_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_norm", psum_norm, 8'd0);
    chk("rst_idx", norm_idx, 2'd0);
    chk("rst_last", norm_last, 1'b0);
    chk("rst_sign", norm_sign, 1'b0);
    reset = 1'b0;
    #1;
    chk("rel_s_ready", s_ready, 2'b11);

    // Simultaneous capture, S = 16.
    capture_both(pack(8'd4, -8'sd4, 8'd8, 8'd0));
    chk("s1_busy", busy, 1'b1);
    chk("s1_div_rdy", s_ready, 2'b00);
    frame_s1("s1", 0);
    chk("s1_end_busy", busy, 1'b0);
    chk("s1_end_rdy", s_ready, 2'b11);

    // Staggered capture: core1 first, a repeat core1 pulse is ignored, then core0.
    psum    = pack(8'd1, 8'd1, 8'd8, 8'd0);
    s_valid = 2'b10;
    tick();
    s_valid = 2'b00;
    chk("s2_rdy01", s_ready, 2'b01);
    chk("s2_busy0", busy, 1'b0);
    tick();
    psum    = pack(8'd1, 8'd1, 8'd50, 8'd50);
    s_valid = 2'b10;
    tick();
    s_valid = 2'b00;
    chk("s2_rdy01_b", s_ready, 2'b01);
    chk("s2_busy0_b", busy, 1'b0);
    tick();
    psum    = pack(8'd4, -8'sd4, 8'd77, 8'd77);
    s_valid = 2'b01;
    tick();
    s_valid = 2'b00;
    chk("s2_busy1", busy, 1'b1);
    frame_s1("s2", 0);

    // Saturation, S = 128.
    capture_both(pack(8'd0, 8'd0, -8'sd128, 8'd0));
    expect_elem("s3e0", 9, 8'd0,   1'b0, 2'd0, 1'b0, 0);
    expect_elem("s3e1", 9, 8'd0,   1'b0, 2'd1, 1'b0, 0);
    expect_elem("s3e2", 9, 8'd255, 1'b1, 2'd2, 1'b0, 0);
    expect_elem("s3e3", 9, 8'd0,   1'b0, 2'd3, 1'b1, 0);

    // Zero frame, one-cycle divide.
    capture_both(32'd0);
    expect_elem("s4e0", 1, 8'd0, 1'b0, 2'd0, 1'b0, 0);
    expect_elem("s4e1", 1, 8'd0, 1'b0, 2'd1, 1'b0, 0);
    expect_elem("s4e2", 1, 8'd0, 1'b0, 2'd2, 1'b0, 0);
    expect_elem("s4e3", 1, 8'd0, 1'b0, 2'd3, 1'b1, 0);
    chk("s4_rdy", s_ready, 2'b11);

    // Backpressure on idx1.
    capture_both(pack(8'd4, -8'sd4, 8'd8, 8'd0));
    frame_s1("s5", 5);
    chk("s5_end_rdy", s_ready, 2'b11);

    // Reset midway through idx2's division, then a fresh frame with S = 8.
    capture_both(pack(8'd4, -8'sd4, 8'd8, 8'd0));
    expect_elem("s6e0", 9, 8'd64, 1'b0, 2'd0, 1'b0, 0);
    expect_elem("s6e1", 9, 8'd64, 1'b1, 2'd1, 1'b0, 0);
    tick();
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("s6_rst_rdy", s_ready, 2'b00);
    tick();
    chk("s6_rst_valid", norm_valid, 1'b0);
    reset = 1'b0;
    #1;
    chk("s6_rel_rdy", s_ready, 2'b11);
    chk("s6_rel_busy", busy, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (norm_valid) seen = 1'b1;
    end
    chk("s6_no_valid", seen, 1'b0);
    capture_both(pack(8'd3, -8'sd1, 8'd0, -8'sd4));
    expect_elem("s6n0", 9, 8'd96,  1'b0, 2'd0, 1'b0, 0);
    expect_elem("s6n1", 9, 8'd32,  1'b1, 2'd1, 1'b0, 0);
    expect_elem("s6n2", 9, 8'd0,   1'b0, 2'd2, 1'b0, 0);
    expect_elem("s6n3", 9, 8'd128, 1'b1, 2'd3, 1'b1, 0);
    chk("s6_end_rdy", s_ready, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
